// File: rtl/alu_issue_32.sv
`default_nettype none
// ============================================================================
// alu_issue_32 : R-type execute sequencer; issues one op to alu_32, waits
//                with a timeout, and holds the qualified result for MEM.
// Rev 1.0
// ============================================================================
module alu_issue_32 #(
  parameter int         WORD_SIZE   = 32,
  parameter int         TIMEOUT     = 16,
  parameter logic [3:0] CTL_AND     = 4'h0,
  parameter logic [3:0] CTL_OR      = 4'h1,
  parameter logic [3:0] CTL_ADD     = 4'h2,
  parameter logic [3:0] CTL_ADDU    = 4'h3,
  parameter logic [3:0] CTL_SUB     = 4'h6,
  parameter logic [3:0] CTL_SLT     = 4'h7,
  parameter logic [3:0] CTL_NOR     = 4'hC,
  parameter logic [3:0] CTL_INVALID = 4'hF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_funct,
  input  logic [WORD_SIZE-1:0] in_a,
  input  logic [WORD_SIZE-1:0] in_b,
  input  logic [4:0]           in_dest,
  output logic                 alu_start,
  output logic [3:0]           alu_control,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  input  logic                 alu_finished,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  input  logic                 alu_err_invalid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_result,
  output logic                 out_zero,
  output logic [4:0]           out_dest,
  output logic                 out_write_en,
  output logic                 exc_overflow,
  output logic                 exc_reserved,
  output logic                 exc_timeout
);

  localparam int                CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   trap_q, trap_d;
  logic [4:0]             dest_q, dest_d;
  logic                   in_ready_q, in_ready_d;
  logic                   alu_start_q, alu_start_d;
  logic [3:0]             alu_control_q, alu_control_d;
  logic [WORD_SIZE-1:0]   alu_a_q, alu_a_d;
  logic [WORD_SIZE-1:0]   alu_b_q, alu_b_d;
  logic                   out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0]   out_result_q, out_result_d;
  logic                   out_zero_q, out_zero_d;
  logic [4:0]             out_dest_q, out_dest_d;
  logic                   out_write_en_q, out_write_en_d;
  logic                   exc_overflow_q, exc_overflow_d;
  logic                   exc_reserved_q, exc_reserved_d;
  logic                   exc_timeout_q, exc_timeout_d;
  logic                   ovf_trap;

  function automatic logic [3:0] decode_funct(input logic [5:0] f);
    case (f)
      6'h20:   decode_funct = CTL_ADD;
      6'h21:   decode_funct = CTL_ADDU;
      6'h22,
      6'h23:   decode_funct = CTL_SUB;
      6'h24:   decode_funct = CTL_AND;
      6'h25:   decode_funct = CTL_OR;
      6'h27:   decode_funct = CTL_NOR;
      6'h2A:   decode_funct = CTL_SLT;
      default: decode_funct = CTL_INVALID;
    endcase
  endfunction

  // Only add/sub (0x20/0x22) trap on signed overflow; addu/subu wrap silently.
  assign ovf_trap = alu_overflow & trap_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    trap_d         = trap_q;
    dest_d         = dest_q;
    in_ready_d     = in_ready_q;
    alu_start_d    = alu_start_q;
    alu_control_d  = alu_control_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_zero_d     = out_zero_q;
    out_dest_d     = out_dest_q;
    out_write_en_d = out_write_en_q;
    exc_overflow_d = exc_overflow_q;
    exc_reserved_d = exc_reserved_q;
    exc_timeout_d  = exc_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          alu_a_d       = in_a;
          alu_b_d       = in_b;
          dest_d        = in_dest;
          alu_control_d = decode_funct(in_funct);
          trap_d        = (in_funct == 6'h20) || (in_funct == 6'h22);
          in_ready_d    = 1'b0;
          alu_start_d   = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_start_d = 1'b0;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (alu_finished) begin
          out_valid_d    = 1'b1;
          out_result_d   = alu_result;
          out_zero_d     = alu_zero;
          out_dest_d     = dest_q;
          exc_overflow_d = ovf_trap;
          exc_reserved_d = alu_err_invalid;
          exc_timeout_d  = 1'b0;
          out_write_en_d = !(ovf_trap || alu_err_invalid) && (dest_q != 5'd0);
          state_d        = S_HOLD;
        end else if (cnt_q == TIMEOUT_CNT) begin
          out_valid_d    = 1'b1;
          out_result_d   = '0;
          out_zero_d     = 1'b0;
          out_dest_d     = dest_q;
          exc_overflow_d = 1'b0;
          exc_reserved_d = 1'b0;
          exc_timeout_d  = 1'b1;
          out_write_en_d = 1'b0;
          state_d        = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d    = 1'b0;
          out_write_en_d = 1'b0;
          exc_overflow_d = 1'b0;
          exc_reserved_d = 1'b0;
          exc_timeout_d  = 1'b0;
          in_ready_d     = 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: begin
        in_ready_d = 1'b1;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      trap_q         <= 1'b0;
      dest_q         <= '0;
      in_ready_q     <= 1'b1;
      alu_start_q    <= 1'b0;
      alu_control_q  <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_zero_q     <= 1'b0;
      out_dest_q     <= '0;
      out_write_en_q <= 1'b0;
      exc_overflow_q <= 1'b0;
      exc_reserved_q <= 1'b0;
      exc_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      trap_q         <= trap_d;
      dest_q         <= dest_d;
      in_ready_q     <= in_ready_d;
      alu_start_q    <= alu_start_d;
      alu_control_q  <= alu_control_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_zero_q     <= out_zero_d;
      out_dest_q     <= out_dest_d;
      out_write_en_q <= out_write_en_d;
      exc_overflow_q <= exc_overflow_d;
      exc_reserved_q <= exc_reserved_d;
      exc_timeout_q  <= exc_timeout_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign alu_start    = alu_start_q;
  assign alu_control  = alu_control_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_zero     = out_zero_q;
  assign out_dest     = out_dest_q;
  assign out_write_en = out_write_en_q;
  assign exc_overflow = exc_overflow_q;
  assign exc_reserved = exc_reserved_q;
  assign exc_timeout  = exc_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_32.sv
`default_nettype none
// ============================================================================
// tb_alu_issue_32 : randomized bench with an alu_32 stub and a transaction-
//                   level expectation model checked every cycle.
// Rev 1.0
// ============================================================================
module tb_alu_issue_32;
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [5:0]  in_funct = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [4:0]  in_dest = '0;
  logic        alu_start;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b;
  logic        alu_finished;
  logic [31:0] alu_result;
  logic        alu_zero, alu_overflow, alu_err_invalid;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_dest;
  logic        out_write_en, exc_overflow, exc_reserved, exc_timeout;

  always #5 clock = ~clock;

  alu_issue_32 #(.WORD_SIZE(32), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_a(in_a), .in_b(in_b), .in_dest(in_dest),
    .alu_start(alu_start), .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_finished(alu_finished), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_err_invalid(alu_err_invalid),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_dest(out_dest), .out_write_en(out_write_en),
    .exc_overflow(exc_overflow), .exc_reserved(exc_reserved), .exc_timeout(exc_timeout)
  );

  int n_pass = 0, n_total = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // alu_32 stub: finishes st_d cycles after start unless hung or forced high
  logic        st_armed = 1'b0;
  int          st_cnt = 0, st_d = 0;
  logic        st_hang = 1'b0, st_force = 1'b0;
  logic [31:0] st_res;
  logic        st_ovf, st_inv;
  always @(negedge clock) begin
    if (alu_start) begin st_armed <= 1'b1; st_cnt <= 0; end
    else if (in_ready || out_valid) st_armed <= 1'b0;
    else if (st_armed) st_cnt <= st_cnt + 1;
  end
  always_comb begin
    st_res = '0; st_ovf = 1'b0; st_inv = 1'b0;
    case (alu_control)
      4'h0: st_res = alu_a & alu_b;
      4'h1: st_res = alu_a | alu_b;
      4'h2, 4'h3: begin
        st_res = alu_a + alu_b;
        st_ovf = (alu_a[31] == alu_b[31]) && (st_res[31] != alu_a[31]);
      end
      4'h6: begin
        st_res = alu_a - alu_b;
        st_ovf = (alu_a[31] != alu_b[31]) && (st_res[31] != alu_a[31]);
      end
      4'h7: st_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'hC: st_res = ~(alu_a | alu_b);
      default: st_inv = 1'b1;
    endcase
  end
  assign alu_finished    = st_force | (st_armed & ~st_hang & (st_cnt >= st_d));
  assign alu_result      = st_res;
  assign alu_zero        = (st_res == 32'd0);
  assign alu_overflow    = st_ovf;
  assign alu_err_invalid = st_inv;

  // Expectation model, derived from MIPS funct semantics
  int          cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  logic        m_on = 1'b0, m_pending = 1'b0;
  int          m_acc = 0, m_j = 0;
  logic [31:0] e_a, e_b, e_res;
  logic [3:0]  e_ctl;
  logic [4:0]  e_dest;
  logic        e_zero, e_we;
  logic [2:0]  e_exc;

  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dst, input logic hang);
    logic [31:0] r;
    logic inv, sovf;
    r = '0; inv = 1'b0; sovf = 1'b0;
    case (f)
      6'h20, 6'h21: begin r = a + b; sovf = (a[31] == b[31]) && (r[31] != a[31]); end
      6'h22, 6'h23: begin r = a - b; sovf = (a[31] != b[31]) && (r[31] != a[31]); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h27: r = ~(a | b);
      6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: inv = 1'b1;
    endcase
    case (f)
      6'h20: e_ctl = 4'h2;  6'h21: e_ctl = 4'h3;
      6'h22, 6'h23: e_ctl = 4'h6;
      6'h24: e_ctl = 4'h0;  6'h25: e_ctl = 4'h1;
      6'h27: e_ctl = 4'hC;  6'h2A: e_ctl = 4'h7;
      default: e_ctl = 4'hF;
    endcase
    e_a = a; e_b = b; e_dest = dst;
    if (hang) begin
      e_res = '0; e_zero = 1'b0; e_exc = 3'b001; e_we = 1'b0;
    end else begin
      e_res  = r;
      e_zero = (r == 32'd0);
      e_exc  = {sovf && (f == 6'h20 || f == 6'h22), inv, 1'b0};
      e_we   = (e_exc == 3'b000) && (dst != 5'd0);
    end
  endtask

  always @(negedge clock) begin
    if (m_on) begin
      if (m_pending && cyc >= m_acc) begin
        if (cyc < m_acc + 2 + m_j) begin
          chk("busy_in_ready", in_ready, 0);
          chk("busy_out_valid", out_valid, 0);
          chk("alu_start", alu_start, cyc == m_acc);
          chk("alu_control", alu_control, e_ctl);
          chk("alu_a", alu_a, e_a);
          chk("alu_b", alu_b, e_b);
        end else begin
          chk("hold_in_ready", in_ready, 0);
          chk("hold_out_valid", out_valid, 1);
          chk("hold_alu_start", alu_start, 0);
          chk("out_result", out_result, e_res);
          chk("out_zero", out_zero, e_zero);
          chk("out_dest", out_dest, e_dest);
          chk("out_write_en", out_write_en, e_we);
          chk("exc_ovf_rsv_to", {exc_overflow, exc_reserved, exc_timeout}, e_exc);
        end
      end else begin
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_alu_start", alu_start, 0);
        chk("idle_write_en", out_write_en, 0);
        chk("idle_exc", {exc_overflow, exc_reserved, exc_timeout}, 0);
      end
    end
  end

  logic [31:0] s_res;
  logic        s_zero, s_we;
  logic [2:0]  s_exc;
  logic [3:0]  s_ctl;
  int          s_lat;

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dst, input int d, input logic hang,
                        input logic force_hi, input int hold, input logic do_reset);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!in_ready && guard < 20) begin @(negedge clock); guard++; end
    chk("in_ready_wait", in_ready, 1);
    #1;
    model(f, a, b, dst, hang);
    st_d = d; st_hang = hang; st_force = force_hi;
    m_j = hang ? TO : ((force_hi || d < 1) ? 0 : d - 1);
    in_valid = 1'b1; in_funct = f; in_a = a; in_b = b; in_dest = dst;
    m_acc = cyc + 1; m_pending = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    in_funct = 6'($urandom); in_dest = 5'($urandom);
    if (do_reset) begin
      while (cyc < m_acc + 2) @(negedge clock);
      #1 reset_n = 1'b0; m_pending = 1'b0;
      @(posedge clock); #1 reset_n = 1'b1;
      @(negedge clock);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu_control", alu_control, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      st_hang = 1'b0;
      return;
    end
    guard = 0;
    @(negedge clock);
    while (!out_valid && guard < 40) begin
      out_ready = 1'($urandom % 2);
      @(negedge clock);
      guard++;
    end
    chk("out_valid_wait", out_valid, 1);
    s_lat = cyc - m_acc;
    s_res = out_result; s_zero = out_zero; s_we = out_write_en;
    s_exc = {exc_overflow, exc_reserved, exc_timeout}; s_ctl = alu_control;
    out_ready = 1'b0;
    repeat (hold) @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0; m_pending = 1'b0;
    st_hang = 1'b0; st_force = 1'b0;
  endtask

  logic [5:0] ftab [8];
  initial begin
    ftab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    logic [5:0]  f;
    logic [31:0] a, b;
    logic [4:0]  dst;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_alu_start", alu_start, 0);
    chk("reset_alu_control", alu_control, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_out_result", out_result, 0);
    #1 reset_n = 1'b1; m_on = 1'b1;

    run_op(6'h20, 32'h7FFFFFFF, 32'h1, 5'd5, 0, 0, 1, 1, 0);
    chk("lit_add_res", s_res, 32'h80000000);
    chk("lit_add_ovf", s_exc, 3'b100);
    chk("lit_add_we", s_we, 0);
    chk("lit_add_lat", s_lat, 2);
    run_op(6'h21, 32'h7FFFFFFF, 32'h1, 5'd5, 2, 0, 0, 0, 0);
    chk("lit_addu_exc", s_exc, 3'b000);
    chk("lit_addu_we", s_we, 1);
    run_op(6'h22, 32'd100, 32'd101, 5'd3, 0, 0, 1, 0, 0);
    chk("lit_sub_res", s_res, 32'hFFFFFFFF);
    chk("lit_sub_zero", s_zero, 0);
    chk("lit_sub_we", s_we, 1);
    chk("lit_sub_lat", s_lat, 2);
    run_op(6'h22, 32'd1, 32'd1, 5'd3, 1, 0, 0, 0, 0);
    chk("lit_sub0_res", s_res, 0);
    chk("lit_sub0_zero", s_zero, 1);
    run_op(6'h2A, 32'hFFFFFFFF, 32'h0, 5'd7, 2, 0, 0, 0, 0);
    chk("lit_slt", s_res, 32'd1);
    run_op(6'h24, 32'hFFFFFFFF, 32'hF, 5'd8, 3, 0, 0, 0, 0);
    chk("lit_and", s_res, 32'hF);
    run_op(6'h25, 32'hFFFFFFFF, 32'hF, 5'd0, 0, 0, 0, 0, 0);
    chk("lit_or", s_res, 32'hFFFFFFFF);
    chk("lit_dest0_we", s_we, 0);
    run_op(6'h27, 32'hFFFFFFFF, 32'hF, 5'd9, 1, 0, 0, 0, 0);
    chk("lit_nor", s_res, 32'h0);
    run_op(6'h3F, 32'h12345678, 32'h9, 5'd4, 1, 0, 0, 0, 0);
    chk("lit_inv_ctl", s_ctl, 4'hF);
    chk("lit_inv_exc", s_exc, 3'b010);
    chk("lit_inv_we", s_we, 0);
    run_op(6'h20, 32'd7, 32'd8, 5'd6, 0, 1, 0, 5, 0);
    chk("lit_to_lat", s_lat, 6);
    chk("lit_to_exc", s_exc, 3'b001);
    chk("lit_to_res", s_res, 0);
    run_op(6'h20, 32'd7, 32'd8, 5'd6, 0, 1, 0, 0, 1);
    run_op(6'h20, 32'd2, 32'd3, 5'd10, 1, 0, 0, 0, 0);
    chk("lit_after_rst_res", s_res, 32'd5);
    chk("lit_after_rst_we", s_we, 1);

    for (int i = 0; i < 60; i++) begin
      f = ($urandom % 10 < 8) ? ftab[$urandom % 8] : 6'($urandom);
      case ($urandom % 4)
        0: a = 32'h7FFFFFFF;
        1: a = 32'h80000000;
        default: a = $urandom;
      endcase
      b = ($urandom % 4 == 0) ? a : $urandom;
      dst = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
      run_op(f, a, b, dst, int'($urandom % 4), ($urandom % 12 == 0),
             ($urandom % 6 == 0), int'($urandom % 4), ($urandom % 20 == 0));
    end

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
